// File: rtl/msk_loader_pkg.sv
// Shared types and index helpers for the masked shift loader.
package msk_loader_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } loader_state_t;

    // Width of a counter that can hold the values 0..words.
    function automatic int cnt_w(input int words);
        return $clog2(words + 1);
    endfunction

    // LSB position of word k inside a flattened shared block.
    function automatic int word_lsb(input int k, input int width, input int shares);
        return k * width * shares;
    endfunction

endpackage

// File: rtl/msk_word_reg_en.sv
// One word of masked share registers. Each share bit stays in its own lane;
// the register simply holds its value whenever en is low.
module msk_word_reg_en #(
    parameter int d     = 2,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [WIDTH*d-1:0]   in,
    output logic [WIDTH*d-1:0]   out
);

    // Load the whole shared word when enabled, otherwise hold.
    always_ff @(posedge clk) begin
        if (en) begin
            out <= in;
        end
    end

endmodule

// File: rtl/msk_shift_loader.sv
// Masked input loader: shifts shared words into a bank of enable-gated
// registers and presents the full block with a valid/ready handshake.
// Optional build macro MSK_LOADER_CLEAR_EN zeroes the share registers on
// reset and after each consumed block so no stale shares linger.
module msk_shift_loader
    import msk_loader_pkg::*;
#(
    parameter int d     = 2,
    parameter int WIDTH = 8,
    parameter int WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH*d-1:0]         in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORDS*WIDTH*d-1:0]   out_data,
    output logic                       busy
);

    localparam int CNT_W = cnt_w(WORDS);
    localparam int WW    = WIDTH * d;

    loader_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             out_hs;
    logic [WW-1:0]    slot_q [WORDS];

    assign in_ready = (state == FILL) | out_ready;
    assign accept   = in_valid & in_ready;
    assign out_hs   = (state == FULL) & out_ready;

    // Fill/full control: counts accepted words, raises out_valid once the
    // bank is full, and lets a consume overlap with the next block's first word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            cnt       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        busy <= 1'b1;
                        if (cnt == CNT_W'(WORDS - 1)) begin
                            state     <= FULL;
                            cnt       <= '0;
                            out_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (out_hs) begin
                        state     <= FILL;
                        out_valid <= 1'b0;
                        if (accept) begin
                            cnt  <= CNT_W'(1);
                            busy <= 1'b1;
                        end else begin
                            cnt  <= '0;
                            busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= FILL;
                    cnt       <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < WORDS; k++) begin : g_slot
        logic [WW-1:0] shift_val;
        logic [WW-1:0] slot_d;
        logic          slot_en;

        if (k == WORDS - 1) begin : g_top
            assign shift_val = in_data;
        end else begin : g_mid
            assign shift_val = slot_q[k+1];
        end

`ifdef MSK_LOADER_CLEAR_EN
        if (k == WORDS - 1) begin : g_clr_top
            assign slot_d = (rst | (out_hs & ~accept)) ? '0 : shift_val;
        end else begin : g_clr_mid
            assign slot_d = (rst | out_hs) ? '0 : shift_val;
        end
        assign slot_en = rst | accept | out_hs;
`else
        assign slot_d  = shift_val;
        assign slot_en = accept & ~rst;
`endif

        msk_word_reg_en #(
            .d     (d),
            .WIDTH (WIDTH)
        ) u_word (
            .clk (clk),
            .en  (slot_en),
            .in  (slot_d),
            .out (slot_q[k])
        );

        assign out_data[word_lsb(k, WIDTH, d) +: WW] = slot_q[k];
    end

endmodule

// File: tb/tb_msk_shift_loader.sv
// Directed self-checking bench for msk_shift_loader (d=2, WIDTH=8, WORDS=4).
// Honours MSK_LOADER_CLEAR_EN to match the build of the design under test.
module tb_msk_shift_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    int          passed;
    int          total;
    logic [15:0] exp_w [4];
    logic [63:0] saved;

    msk_shift_loader #(
        .d     (2),
        .WIDTH (8),
        .WORDS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Build a shared word: share0 = mask, share1 = value ^ mask, interleaved per bit.
    function automatic logic [15:0] pack(input logic [7:0] v, input logic [7:0] m);
        logic [15:0] r;
        for (int i = 0; i < 8; i++) begin
            r[2*i]   = m[i];
            r[2*i+1] = v[i] ^ m[i];
        end
        return r;
    endfunction

    // Recombine a shared word to its unmasked value.
    function automatic logic [7:0] unmask(input logic [15:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = w[2*i] ^ w[2*i+1];
        end
        return r;
    endfunction

    function automatic logic [15:0] slot(input logic [63:0] blk, input int k);
        return blk[k*16 +: 16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", out_valid);
        else passed++;
        total++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", in_ready);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy);
        else passed++;
        total++;
        if (dut.cnt !== 3'd0) $display("[TB] FAIL reset_cnt got %0d want 0", dut.cnt);
        else passed++;
`ifdef MSK_LOADER_CLEAR_EN
        total++;
        if (out_data !== 64'h0) $display("[TB] FAIL reset_clear got %h want 0", out_data);
        else passed++;
`endif
    endtask

    task automatic test_fill();
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_w[k] = pack(vals[k], 8'($urandom_range(0, 255)));
            in_valid = 1'b1;
            in_data = exp_w[k];
            tick();
            if (k < 3) begin
                total++;
                if (out_valid !== 1'b0) $display("[TB] FAIL fill_early_valid k=%0d got %b want 0", k, out_valid);
                else passed++;
            end
        end
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1) $display("[TB] FAIL fill_out_valid got %b want 1", out_valid);
        else passed++;
        total++;
        if (busy !== 1'b1) $display("[TB] FAIL fill_busy got %b want 1", busy);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (unmask(slot(out_data, k)) !== vals[k])
                $display("[TB] FAIL fill_unmask slot%0d got %h want %h", k, unmask(slot(out_data, k)), vals[k]);
            else passed++;
            total++;
            if (slot(out_data, k) !== exp_w[k])
                $display("[TB] FAIL fill_lanes slot%0d got %h want %h", k, slot(out_data, k), exp_w[k]);
            else passed++;
        end
    endtask

    task automatic test_hold();
        saved = {exp_w[3], exp_w[2], exp_w[1], exp_w[0]};
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = pack(8'hEE, 8'h5A);
        for (int c = 0; c < 10; c++) begin
            total++;
            if (in_ready !== 1'b0) $display("[TB] FAIL hold_in_ready c=%0d got %b want 0", c, in_ready);
            else passed++;
            tick();
            total++;
            if (out_data !== saved || out_valid !== 1'b1 || dut.cnt !== 3'd0)
                $display("[TB] FAIL hold_stable c=%0d got %h/%b/%0d want %h/1/0", c, out_data, out_valid, dut.cnt, saved);
            else passed++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [4];
        vals[0] = 8'h55; vals[1] = 8'h66; vals[2] = 8'h77; vals[3] = 8'h88;
        exp_w[0] = pack(vals[0], 8'($urandom_range(0, 255)));
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = exp_w[0];
        #1;
        total++;
        if (in_ready !== 1'b1) $display("[TB] FAIL b2b_in_ready got %b want 1", in_ready);
        else passed++;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || dut.cnt !== 3'd1 || busy !== 1'b1)
            $display("[TB] FAIL b2b_state got valid=%b cnt=%0d busy=%b want 0/1/1", out_valid, dut.cnt, busy);
        else passed++;
        total++;
        if (slot(out_data, 3) !== exp_w[0]) $display("[TB] FAIL b2b_slot3 got %h want %h", slot(out_data, 3), exp_w[0]);
        else passed++;
        for (int k = 1; k < 4; k++) begin
            exp_w[k] = pack(vals[k], 8'($urandom_range(0, 255)));
            in_data = exp_w[k];
            tick();
        end
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1) $display("[TB] FAIL b2b_out_valid got %b want 1", out_valid);
        else passed++;
        total++;
        if (out_data !== {exp_w[3], exp_w[2], exp_w[1], exp_w[0]})
            $display("[TB] FAIL b2b_block got %h want %h", out_data, {exp_w[3], exp_w[2], exp_w[1], exp_w[0]});
        else passed++;
        total++;
        if (unmask(slot(out_data, 0)) !== 8'h55) $display("[TB] FAIL b2b_slot0 got %h want 55", unmask(slot(out_data, 0)));
        else passed++;
    endtask

    task automatic test_consume();
        saved = out_data;
        out_ready = 1'b1;
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || dut.cnt !== 3'd0)
            $display("[TB] FAIL consume_state got valid=%b busy=%b cnt=%0d want 0/0/0", out_valid, busy, dut.cnt);
        else passed++;
`ifdef MSK_LOADER_CLEAR_EN
        total++;
        if (out_data !== 64'h0) $display("[TB] FAIL consume_clear got %h want 0", out_data);
        else passed++;
`else
        total++;
        if (out_data !== saved) $display("[TB] FAIL consume_hold got %h want %h", out_data, saved);
        else passed++;
`endif
    endtask

    task automatic test_gaps();
        logic       pat [7];
        logic [7:0] vals [4];
        int         n;
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0; pat[5] = 1; pat[6] = 1;
        vals[0] = 8'hA1; vals[1] = 8'hA2; vals[2] = 8'hA3; vals[3] = 8'hA4;
        n = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if (pat[c]) begin
                exp_w[n] = pack(vals[n], 8'($urandom_range(0, 255)));
                in_data = exp_w[n];
                in_valid = 1'b1;
                n++;
            end else begin
                in_valid = 1'b0;
                in_data = 16'hDEAD;
            end
            tick();
            total++;
            if (out_valid !== (n == 4)) $display("[TB] FAIL gaps_valid c=%0d got %b want %b", c, out_valid, (n == 4));
            else passed++;
        end
        in_valid = 1'b0;
        total++;
        if (out_data !== {exp_w[3], exp_w[2], exp_w[1], exp_w[0]})
            $display("[TB] FAIL gaps_block got %h want %h", out_data, {exp_w[3], exp_w[2], exp_w[1], exp_w[0]});
        else passed++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] vals [4];
        vals[0] = 8'hC1; vals[1] = 8'hC2; vals[2] = 8'hC3; vals[3] = 8'hC4;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = pack(8'h99, 8'h3C);
        tick();
        tick();
        total++;
        if (busy !== 1'b1 || dut.cnt !== 3'd2) $display("[TB] FAIL mid_busy got busy=%b cnt=%0d want 1/2", busy, dut.cnt);
        else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || dut.cnt !== 3'd0 || in_ready !== 1'b1)
            $display("[TB] FAIL mid_reset got valid=%b busy=%b cnt=%0d rdy=%b want 0/0/0/1", out_valid, busy, dut.cnt, in_ready);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            exp_w[k] = pack(vals[k], 8'($urandom_range(0, 255)));
            in_valid = 1'b1;
            in_data = exp_w[k];
            tick();
        end
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1) $display("[TB] FAIL mid_reload_valid got %b want 1", out_valid);
        else passed++;
        total++;
        if (out_data !== {exp_w[3], exp_w[2], exp_w[1], exp_w[0]})
            $display("[TB] FAIL mid_reload_block got %h want %h", out_data, {exp_w[3], exp_w[2], exp_w[1], exp_w[0]});
        else passed++;
    endtask

    // Run every scenario in order, then report.
    initial begin
        passed = 0;
        total = 0;
        test_reset();
        test_fill();
        test_hold();
        test_back_to_back();
        test_consume();
        test_gaps();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
